// File: rtl/systolic_ws_pkg.sv
// Shared definitions for the weight-stationary result drain.
//   acc_width() : accumulator width derived from the operand width
//   drain_state_e : drain FSM states (WAIT: row k filling, SEND: row k presented)
package systolic_ws_pkg;

    // Accumulated results carry four operand widths of headroom.
    function automatic int unsigned acc_width(input int unsigned data_width);
        return data_width * 4;
    endfunction

    typedef enum logic {
        WAIT = 1'b0,
        SEND = 1'b1
    } drain_state_e;

endpackage

// File: rtl/systolic_ws_drain_bank.sv
// One result column: ROW_NUM words of storage plus the per-row filled mask.
// Ports:
//   clk, reset          clock, async active-low reset (clears the mask only)
//   wr_en/wr_addr/wr_data  column write from the array
//   clr_en/clr_addr     drain clears one row's mask bit
//   rd_addr/rd_data_c   combinational read of the row being drained
//   filled              registered per-row filled mask
//   dup_c               write dropped because its slot is still undrained
module systolic_ws_drain_bank
    import systolic_ws_pkg::*;
#(
    parameter  int unsigned ACC_WIDTH      = acc_width(8),
    parameter  int unsigned ROW_NUM        = 8,
    localparam int unsigned ROW_ADDR_WIDTH = $clog2(ROW_NUM)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      wr_en,
    input  logic [ROW_ADDR_WIDTH-1:0] wr_addr,
    input  logic [ACC_WIDTH-1:0]      wr_data,
    input  logic                      clr_en,
    input  logic [ROW_ADDR_WIDTH-1:0] clr_addr,
    input  logic [ROW_ADDR_WIDTH-1:0] rd_addr,
    output logic [ACC_WIDTH-1:0]      rd_data_c,
    output logic [ROW_NUM-1:0]        filled,
    output logic                      dup_c
);

    logic [ACC_WIDTH-1:0] mem [ROW_NUM];
    logic [ROW_NUM-1:0]   filled_d;
    logic                 accept_c;

    // A slot being cleared on this edge is free: the write starts the next matrix.
    always_comb begin
        accept_c = wr_en && (!filled[wr_addr] || (clr_en && (clr_addr == wr_addr)));
        dup_c    = wr_en && !accept_c;
        filled_d = filled;
        if (clr_en) begin
            filled_d[clr_addr] = 1'b0;
        end
        if (accept_c) begin
            filled_d[wr_addr] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            filled <= '0;
        end else begin
            filled <= filled_d;
        end
    end

    // Storage needs no reset; the mask alone decides validity.
    always_ff @(posedge clk) begin
        if (accept_c) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data_c = mem[rd_addr];

endmodule

// File: rtl/systolic_ws_drain.sv
// Reassembles skewed per-column results into complete rows and drains them
// in ascending row order over a valid/ready interface.
// Ports:
//   clk, reset                 clock, async active-low reset
//   row_data_in/row_wraddr/row_wr_en  per-column writes from the array
//   out_val/out_rdy            row handshake
//   out_data/out_row_idx       presented row contents and index
//   mat_done                   pulse after the last row of a matrix is accepted
//   err_overwrite              sticky: a write hit an undrained slot
module systolic_ws_drain
    import systolic_ws_pkg::*;
#(
    parameter  int unsigned DATA_WIDTH     = 8,
    parameter  int unsigned ROW_NUM        = 8,
    parameter  int unsigned COL_NUM        = 8,
    localparam int unsigned ACC_WIDTH      = acc_width(DATA_WIDTH),
    localparam int unsigned ROW_ADDR_WIDTH = $clog2(ROW_NUM)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [ACC_WIDTH-1:0]      row_data_in [0:COL_NUM-1],
    input  logic [ROW_ADDR_WIDTH-1:0] row_wraddr  [0:COL_NUM-1],
    input  logic                      row_wr_en   [0:COL_NUM-1],
    output logic                      out_val,
    input  logic                      out_rdy,
    output logic [ACC_WIDTH-1:0]      out_data    [0:COL_NUM-1],
    output logic [ROW_ADDR_WIDTH-1:0] out_row_idx,
    output logic                      mat_done,
    output logic                      err_overwrite
);

    localparam logic [ROW_ADDR_WIDTH-1:0] LAST_ROW = ROW_ADDR_WIDTH'(ROW_NUM - 1);

    drain_state_e              state, state_d;
    logic [ROW_ADDR_WIDTH-1:0] k, k_d;
    logic                      load_c;
    logic                      mat_done_d;
    logic [COL_NUM-1:0]        col_full_c;
    logic [COL_NUM-1:0]        dup_c;
    logic [ROW_NUM-1:0]        bank_filled [COL_NUM];
    logic [ACC_WIDTH-1:0]      rd_data_c   [COL_NUM];

    // Column banks; the row being drained is read and cleared through k.
    for (genvar c = 0; c < COL_NUM; c++) begin : g_bank
        systolic_ws_drain_bank #(
            .ACC_WIDTH (ACC_WIDTH),
            .ROW_NUM   (ROW_NUM)
        ) u_bank (
            .clk       (clk),
            .reset     (reset),
            .wr_en     (row_wr_en[c]),
            .wr_addr   (row_wraddr[c]),
            .wr_data   (row_data_in[c]),
            .clr_en    (load_c),
            .clr_addr  (k),
            .rd_addr   (k),
            .rd_data_c (rd_data_c[c]),
            .filled    (bank_filled[c]),
            .dup_c     (dup_c[c])
        );
    end

    // FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= WAIT;
            k     <= '0;
        end else begin
            state <= state_d;
            k     <= k_d;
        end
    end

    // Next state: wait for row k to fill, then hold it until accepted.
    always_comb begin
        state_d    = state;
        k_d        = k;
        load_c     = 1'b0;
        mat_done_d = 1'b0;
        for (int c = 0; c < COL_NUM; c++) begin
            col_full_c[c] = bank_filled[c][k];
        end
        case (state)
            WAIT: begin
                if (&col_full_c) begin
                    load_c  = 1'b1;
                    state_d = SEND;
                end
            end
            SEND: begin
                if (out_rdy) begin
                    state_d    = WAIT;
                    mat_done_d = (k == LAST_ROW);
                    k_d        = (k == LAST_ROW) ? '0 : k + ROW_ADDR_WIDTH'(1);
                end
            end
            default: state_d = WAIT;
        endcase
    end

    // Output registers; out_data is a private copy so later writes to row k cannot disturb it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_val       <= 1'b0;
            out_row_idx   <= '0;
            mat_done      <= 1'b0;
            err_overwrite <= 1'b0;
            for (int c = 0; c < COL_NUM; c++) begin
                out_data[c] <= '0;
            end
        end else begin
            out_val       <= (state_d == SEND);
            mat_done      <= mat_done_d;
            err_overwrite <= err_overwrite | (|dup_c);
            if (load_c) begin
                out_row_idx <= k;
                for (int c = 0; c < COL_NUM; c++) begin
                    out_data[c] <= rd_data_c[c];
                end
            end
        end
    end

endmodule
